// File: rtl/frame_responder.sv
// Frame receiver: checks session ordering and a bit-serial CRC-32 over a full
// frame, then answers the sender with OKAY / ERROR / FATAL_ERROR.
module frame_responder #(
  parameter int          DATA_SIZE     = 64,
  parameter int          PREAMBLE_SIZE = 7,
  parameter int          CRC_SIZE      = 4,
  parameter int          FRAME_SIZE    = (PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE) * 8 - 1,
  parameter logic [32:0] CRC_POLY      = 33'h104c11db7,
  parameter int          MAX_RETRY     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [0:FRAME_SIZE] Fin,
  input  logic              Fin_valid,
  output logic [0:FRAME_SIZE] Fout,
  output logic              Fout_valid,
  output logic [7:0]        confirm,
  output logic              confirm_valid,
  output logic              busy,
  output logic [1:0]        state_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CHECK   = 2'd1;
  localparam logic [1:0] S_CRC     = 2'd2;
  localparam logic [1:0] S_RESPOND = 2'd3;

  localparam logic [7:0] T_FIRST  = 8'h00;
  localparam logic [7:0] T_LAST   = 8'h01;
  localparam logic [7:0] T_NORMAL = 8'h02;
  localparam logic [7:0] T_SINGLE = 8'h03;

  localparam logic [7:0] C_OKAY  = 8'h05;
  localparam logic [7:0] C_ERROR = 8'h04;
  localparam logic [7:0] C_FATAL = 8'h08;

  localparam int             CW         = $clog2(FRAME_SIZE + 1);
  localparam int             FW         = $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0]  LAST_BIT   = CW'(FRAME_SIZE);
  localparam logic [FW-1:0]  FAIL_LIMIT = FW'(MAX_RETRY - 1);

  logic [1:0]          state_q, state_d;
  logic [0:FRAME_SIZE] frame_q, fout_q;
  logic [CW-1:0]       bit_cnt_q;
  logic [31:0]         crc_q, crc_d, last_q;
  logic                sess_q;
  logic [FW-1:0]       fail_cnt_q;
  logic [7:0]          code_q, code_d, final_code, confirm_q;
  logic                confirm_valid_q, fout_valid_q;
  logic [7:0]          ftype;
  logic [31:0]         fnum;
  logic                rule_ok, type_known, crc_fb;

  assign ftype = frame_q[0:7];
  assign fnum  = frame_q[24:55];

  // One division step per cycle, MSB of the frame first, remainder starts at 0.
  assign crc_fb = crc_q[31] ^ frame_q[bit_cnt_q];
  assign crc_d  = {crc_q[30:0], 1'b0} ^ (crc_fb ? CRC_POLY[31:0] : 32'h0);

  always_comb begin
    rule_ok    = 1'b0;
    type_known = 1'b1;
    case (ftype)
      T_FIRST, T_SINGLE: rule_ok = !sess_q;
      T_NORMAL, T_LAST:  rule_ok = sess_q && (fnum == last_q + 32'd1);
      default:           type_known = 1'b0;
    endcase
  end

  // An ERROR that would reach the retry limit escalates to FATAL_ERROR.
  always_comb begin
    final_code = code_q;
    if (code_q == C_ERROR && fail_cnt_q == FAIL_LIMIT) final_code = C_FATAL;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE:  if (Fin_valid) state_d = S_CHECK;
      S_CHECK: begin
        if (!type_known) begin
          state_d = S_RESPOND;
          code_d  = C_FATAL;
        end else if (!rule_ok) begin
          state_d = S_RESPOND;
          code_d  = C_ERROR;
        end else begin
          state_d = S_CRC;
        end
      end
      S_CRC: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d = S_RESPOND;
          code_d  = (crc_d == 32'h0) ? C_OKAY : C_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      frame_q         <= '0;
      fout_q          <= '0;
      bit_cnt_q       <= '0;
      crc_q           <= '0;
      last_q          <= '0;
      sess_q          <= 1'b0;
      fail_cnt_q      <= '0;
      code_q          <= '0;
      confirm_q       <= '0;
      confirm_valid_q <= 1'b0;
      fout_valid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      code_q          <= code_d;
      confirm_valid_q <= 1'b0;
      fout_valid_q    <= 1'b0;
      case (state_q)
        S_IDLE: if (Fin_valid) frame_q <= Fin;
        S_CHECK: begin
          bit_cnt_q <= '0;
          crc_q     <= '0;
        end
        S_CRC: begin
          bit_cnt_q <= bit_cnt_q + CW'(1);
          crc_q     <= crc_d;
        end
        default: begin
          // RESPOND: publish the code and apply the session bookkeeping.
          confirm_q       <= final_code;
          confirm_valid_q <= 1'b1;
          if (final_code == C_OKAY) begin
            fail_cnt_q   <= '0;
            fout_q       <= frame_q;
            fout_valid_q <= 1'b1;
            case (ftype)
              T_FIRST:  begin sess_q <= 1'b1; last_q <= fnum;  end
              T_NORMAL: last_q <= fnum;
              T_LAST:   begin sess_q <= 1'b0; last_q <= 32'h0; end
              default:  ;
            endcase
          end else if (final_code == C_FATAL) begin
            sess_q     <= 1'b0;
            last_q     <= 32'h0;
            fail_cnt_q <= '0;
          end else begin
            fail_cnt_q <= fail_cnt_q + FW'(1);
          end
        end
      endcase
    end
  end

  assign Fout          = fout_q;
  assign Fout_valid    = fout_valid_q;
  assign confirm       = confirm_q;
  assign confirm_valid = confirm_valid_q;
  assign busy          = (state_q != S_IDLE);
  assign state_o       = state_q;

endmodule

// File: tb/tb_frame_responder.sv
// Directed scenarios for frame_responder: session rules, CRC acceptance,
// retry escalation, dropped pulses while busy and reset mid-frame.
module tb_frame_responder;

  localparam int FS      = 599;
  localparam int CRC_POS = FS + 1 - 32;

  localparam logic [7:0] T_FIRST  = 8'h00;
  localparam logic [7:0] T_LAST   = 8'h01;
  localparam logic [7:0] T_NORMAL = 8'h02;
  localparam logic [7:0] T_SINGLE = 8'h03;

  logic          clk;
  logic          rst_n;
  logic [0:FS]   Fin;
  logic          Fin_valid;
  logic [0:FS]   Fout;
  logic          Fout_valid;
  logic [7:0]    confirm;
  logic          confirm_valid;
  logic          busy;
  logic [1:0]    state_o;

  int errors = 0;
  int checks = 0;

  frame_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Fin           (Fin),
    .Fin_valid     (Fin_valid),
    .Fout          (Fout),
    .Fout_valid    (Fout_valid),
    .confirm       (confirm),
    .confirm_valid (confirm_valid),
    .busy          (busy),
    .state_o       (state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n     = 1'b0;
    Fin_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame builder; the CRC is the remainder of (header+payload) * x^32 by the
  // CRC-32 polynomial, computed by augmented long division.
  function automatic logic [0:FS] make_frame(input logic [7:0] ftype,
                                             input logic [31:0] num,
                                             input int flip);
    logic [0:FS] f;
    logic [31:0] r;
    logic        top, b;
    f = '0;
    f[0 +: 8]  = ftype;
    f[8 +: 8]  = 8'h55;
    f[16 +: 8] = 8'hAA;
    f[24 +: 32] = num;
    for (int k = 0; k < 64; k++) f[56 + 8 * k +: 8] = 8'(k * 29 + 7) ^ num[7:0];
    r = 32'h0;
    for (int i = 0; i < CRC_POS + 32; i++) begin
      b   = (i < CRC_POS) ? f[i] : 1'b0;
      top = r[31];
      r   = {r[30:0], b};
      if (top) r = r ^ 32'h04c11db7;
    end
    f[CRC_POS +: 32] = r;
    if (flip >= 0) f[flip] = ~f[flip];
    return f;
  endfunction

  // Driver tasks
  task automatic send_frame(input logic [0:FS] f);
    Fin       = f;
    Fin_valid = 1'b1;
    step();
    Fin_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output logic [7:0] code, output logic fv);
    lat  = -1;
    code = 8'hxx;
    fv   = 1'b0;
    for (int n = 1; n <= 700; n++) begin
      step();
      if (Fout_valid) fv = 1'b1;
      if (confirm_valid) begin
        lat  = n;
        code = confirm;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (confirm_valid !== 1'b0) begin errors++; $display("FAIL reset_cv got=%b exp=0", confirm_valid); end
    apply_reset();
    checks++; if (confirm !== 8'h00) begin errors++; $display("FAIL reset_confirm got=%h exp=00", confirm); end
    checks++; if (Fout_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", Fout_valid); end
    checks++; if (Fout !== '0) begin errors++; $display("FAIL reset_fout got=%h exp=0", Fout); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
  endtask

  task automatic test_single();
    logic [0:FS] f;
    int lat; logic [7:0] code; logic fv;
    apply_reset();
    f = make_frame(T_SINGLE, 32'h0000_1234, -1);
    send_frame(f);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    wait_resp(lat, code, fv);
    checks++; if (lat !== 602) begin errors++; $display("FAIL single_lat got=%0d exp=602", lat); end
    checks++; if (code !== 8'h05) begin errors++; $display("FAIL single_code got=%h exp=05", code); end
    checks++; if (fv !== 1'b1) begin errors++; $display("FAIL single_fv got=%b exp=1", fv); end
    checks++; if (Fout !== f) begin errors++; $display("FAIL single_fout got=%h exp=%h", Fout, f); end
    step();
    checks++; if (confirm_valid !== 1'b0 || confirm !== 8'h05) begin errors++; $display("FAIL single_hold got=%b/%h exp=0/05", confirm_valid, confirm); end
    checks++; if (Fout_valid !== 1'b0 || Fout !== f) begin errors++; $display("FAIL single_fout_hold got=%b exp=0", Fout_valid); end
  endtask

  task automatic test_session();
    logic [7:0]  tt [4];
    logic [31:0] nn [4];
    logic [7:0]  ec [4];
    int          el [4];
    logic [0:FS] f, last_ok;
    int lat; logic [7:0] code; logic fv;
    tt = '{T_FIRST, T_NORMAL, T_LAST, T_NORMAL};
    nn = '{32'h10, 32'h11, 32'h12, 32'h13};
    ec = '{8'h05, 8'h05, 8'h05, 8'h04};
    el = '{602, 602, 602, 2};
    apply_reset();
    last_ok = '0;
    for (int i = 0; i < 4; i++) begin
      f = make_frame(tt[i], nn[i], -1);
      if (ec[i] == 8'h05) last_ok = f;
      send_frame(f);
      wait_resp(lat, code, fv);
      checks++; if (lat !== el[i]) begin errors++; $display("FAIL session_lat[%0d] got=%0d exp=%0d", i, lat, el[i]); end
      checks++; if (code !== ec[i]) begin errors++; $display("FAIL session_code[%0d] got=%h exp=%h", i, code, ec[i]); end
      checks++; if (fv !== (ec[i] == 8'h05)) begin errors++; $display("FAIL session_fv[%0d] got=%b", i, fv); end
      checks++; if (Fout !== last_ok) begin errors++; $display("FAIL session_fout[%0d] got=%h exp=%h", i, Fout, last_ok); end
    end
  endtask

  task automatic test_crc_error();
    logic [0:FS] f [3];
    logic [7:0]  ec [3];
    logic [0:FS] last_ok;
    int lat; logic [7:0] code; logic fv;
    f[0] = make_frame(T_FIRST, 32'h10, -1);
    f[1] = make_frame(T_NORMAL, 32'h11, 100);
    f[2] = make_frame(T_NORMAL, 32'h11, -1);
    ec = '{8'h05, 8'h04, 8'h05};
    apply_reset();
    last_ok = '0;
    for (int i = 0; i < 3; i++) begin
      if (ec[i] == 8'h05) last_ok = f[i];
      send_frame(f[i]);
      wait_resp(lat, code, fv);
      checks++; if (lat !== 602) begin errors++; $display("FAIL crcerr_lat[%0d] got=%0d exp=602", i, lat); end
      checks++; if (code !== ec[i]) begin errors++; $display("FAIL crcerr_code[%0d] got=%h exp=%h", i, code, ec[i]); end
      checks++; if (fv !== (ec[i] == 8'h05)) begin errors++; $display("FAIL crcerr_fv[%0d] got=%b", i, fv); end
      checks++; if (Fout !== last_ok) begin errors++; $display("FAIL crcerr_fout[%0d] got=%h exp=%h", i, Fout, last_ok); end
    end
  endtask

  task automatic test_retry();
    logic [0:FS] f [5];
    logic [7:0]  ec [5];
    int          el [5];
    int lat; logic [7:0] code; logic fv;
    f[0] = make_frame(T_FIRST, 32'h10, -1);
    f[1] = make_frame(T_NORMAL, 32'h11, 300);
    f[2] = f[1];
    f[3] = f[1];
    f[4] = make_frame(T_NORMAL, 32'h11, -1);
    ec = '{8'h05, 8'h04, 8'h04, 8'h08, 8'h04};
    el = '{602, 602, 602, 602, 2};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      send_frame(f[i]);
      wait_resp(lat, code, fv);
      checks++; if (lat !== el[i]) begin errors++; $display("FAIL retry_lat[%0d] got=%0d exp=%0d", i, lat, el[i]); end
      checks++; if (code !== ec[i]) begin errors++; $display("FAIL retry_code[%0d] got=%h exp=%h", i, code, ec[i]); end
    end
  endtask

  task automatic test_fatal_wrap();
    logic [0:FS] f [3];
    logic [7:0]  ec [3];
    int          el [3];
    int lat; logic [7:0] code; logic fv;
    f[0] = make_frame(8'h09, 32'h5, -1);
    f[1] = make_frame(T_FIRST, 32'hFFFF_FFFF, -1);
    f[2] = make_frame(T_NORMAL, 32'h0000_0000, -1);
    ec = '{8'h08, 8'h05, 8'h05};
    el = '{2, 602, 602};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      send_frame(f[i]);
      wait_resp(lat, code, fv);
      checks++; if (lat !== el[i]) begin errors++; $display("FAIL fatalwrap_lat[%0d] got=%0d exp=%0d", i, lat, el[i]); end
      checks++; if (code !== ec[i]) begin errors++; $display("FAIL fatalwrap_code[%0d] got=%h exp=%h", i, code, ec[i]); end
      checks++; if (fv !== (ec[i] == 8'h05)) begin errors++; $display("FAIL fatalwrap_fv[%0d] got=%b", i, fv); end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:FS] f, g;
    int lat; logic [7:0] code; logic fv;
    int extra;
    apply_reset();
    f = make_frame(T_SINGLE, 32'h0000_00A5, -1);
    g = make_frame(T_SINGLE, 32'h0000_005A, -1);
    send_frame(f);
    repeat (3) step();
    Fin       = g;
    Fin_valid = 1'b1;
    step();
    Fin_valid = 1'b0;
    wait_resp(lat, code, fv);
    checks++; if (lat !== 598) begin errors++; $display("FAIL b2b_lat got=%0d exp=598", lat); end
    checks++; if (code !== 8'h05) begin errors++; $display("FAIL b2b_code got=%h exp=05", code); end
    checks++; if (Fout !== f) begin errors++; $display("FAIL b2b_fout got=%h exp=%h", Fout, f); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    send_frame(make_frame(8'h09, 32'h1, -1));
    wait_resp(lat, code, fv);
    checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_next_lat got=%0d exp=2", lat); end
    checks++; if (code !== 8'h08) begin errors++; $display("FAIL b2b_next_code got=%h exp=08", code); end
    extra = 0;
    repeat (10) begin
      step();
      if (confirm_valid) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_quiet got=%0d exp=0", extra); end
  endtask

  task automatic test_mid_reset();
    logic [0:FS] f;
    int lat; logic [7:0] code; logic fv;
    int seen;
    apply_reset();
    f = make_frame(T_SINGLE, 32'h0000_0077, -1);
    send_frame(f);
    seen = 0;
    repeat (300) begin
      step();
      if (confirm_valid || Fout_valid) seen++;
    end
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL midrst_in_crc got=%0d exp=2", state_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (Fout !== '0) begin errors++; $display("FAIL midrst_fout got=%h exp=0", Fout); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) begin
      step();
      if (confirm_valid || Fout_valid || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_quiet got=%0d exp=0", seen); end
    send_frame(f);
    wait_resp(lat, code, fv);
    checks++; if (lat !== 602) begin errors++; $display("FAIL midrst_lat got=%0d exp=602", lat); end
    checks++; if (code !== 8'h05) begin errors++; $display("FAIL midrst_code got=%h exp=05", code); end
    checks++; if (Fout !== f) begin errors++; $display("FAIL midrst_fout_after got=%h exp=%h", Fout, f); end
  endtask

  initial begin
    rst_n     = 1'b0;
    Fin       = '0;
    Fin_valid = 1'b0;
    test_reset();
    test_single();
    test_session();
    test_crc_error();
    test_retry();
    test_fatal_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
